// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings, FSM states
// and the store-side lane helpers.
package lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // op[1:0] carries the access size; op[2] only selects zero-extension
    function automatic logic is_misaligned(logic [2:0] op, logic [1:0] off);
        logic mis;
        case (op[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_mask(logic [2:0] op, logic [1:0] off);
        logic [3:0] m;
        case (op[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(logic [2:0] op, logic [31:0] wd);
        logic [31:0] d;
        case (op[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus bundles for the LSU.
interface lsu_core_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              MemRd;
    logic              MemWr;
    logic [2:0]        MemOp;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              misalign;

    modport master (
        output req_valid, MemRd, MemWr, MemOp, addr, wdata,
        input  req_ready, resp_valid, rdata, misalign
    );
    modport slave (
        input  req_valid, MemRd, MemWr, MemOp, addr, wdata,
        output req_ready, resp_valid, rdata, misalign
    );
endinterface

interface lsu_bus_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wmask;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension of a fetched 32-bit word.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (op_i[1:0])
            2'b00: data_o = op_i[2] ? {24'h0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
            2'b01: data_o = op_i[2] ? {16'h0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: one core access at a time, word bus
// with registered request signals and a one-cycle completion pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_core_if.slave  core,
    lsu_bus_if.master  bus
);

    lsu_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_wmask_q, bus_wmask_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    logic              req_ready;
    logic              resp_valid;
    logic              is_access;
    logic [31:0]       ext_data;

    lsu_load_ext u_load_ext (
        .word_i (bus.bus_rdata),
        .op_i   (op_q),
        .off_i  (off_q),
        .data_o (ext_data)
    );

    assign is_access = core.MemRd | core.MemWr;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wmask_d = bus_wmask_q;
        bus_wdata_d = bus_wdata_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (core.req_valid) begin
                    op_d       = core.MemOp;
                    off_d      = core.addr[1:0];
                    bus_we_d   = core.MemWr;
                    misalign_d = 1'b0;
                    if (!is_access) begin
                        state_d = S_RESP;
                    end else if (is_misaligned(core.MemOp, core.addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_addr_d  = {core.addr[ADDR_W-1:2], 2'b00};
                        bus_wmask_d = core.MemWr ? store_mask(core.MemOp, core.addr[1:0])
                                                 : 4'b0000;
                        bus_wdata_d = core.MemWr ? store_data(core.MemOp, core.wdata)
                                                 : 32'h0;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_we_q ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.bus_rvalid) begin
                    rdata_d = ext_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_W;
            off_q       <= 2'b00;
            rdata_q     <= 32'h0;
            misalign_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wmask_q <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wmask_q <= bus_wmask_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign core.req_ready  = req_ready;
    assign core.resp_valid = resp_valid;
    assign core.rdata      = rdata_q;
    assign core.misalign   = misalign_q;

    assign bus.bus_req     = bus_req_q;
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wmask   = bus_wmask_q;
    assign bus.bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected
// responses; a negedge monitor pops and checks them on resp_valid.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_core_if #(.ADDR_W(32)) core ();
    lsu_bus_if  #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .bus  (bus)
    );

    typedef struct {
        logic        mis;
        logic [31:0] rdata;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] last_rd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (core.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_misalign"}, {31'h0, core.misalign}, {31'h0, mon_e.mis});
                chk({mon_e.tag, "_rdata"}, core.rdata, mon_e.rdata);
                chk({mon_e.tag, "_latency"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic access(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          gd,
        input int          rv,
        input logic [31:0] rword,
        input logic [31:0] exp_rd,
        input logic        mis,
        input logic [3:0]  emask,
        input logic [31:0] ewdata
    );
        exp_t e;
        logic busop;
        logic isld;
        int   lat;
        busop = (rd | wr) & ~mis;
        isld  = busop & ~wr;
        lat   = !busop ? 1 : (wr ? 2 + gd : 3 + gd + rv);
        if (isld) last_rd = exp_rd;
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, core.req_ready}, 32'h1);
        core.req_valid = 1'b1;
        core.MemRd     = rd;
        core.MemWr     = wr;
        core.MemOp     = op;
        core.addr      = a;
        core.wdata     = wd;
        e.mis   = mis;
        e.rdata = last_rd;
        e.cyc   = cyc + lat;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clk);
        core.req_valid = 1'b0;
        core.MemRd     = 1'b0;
        core.MemWr     = 1'b0;
        core.addr      = 32'hFFFF_FFFF;
        core.wdata     = 32'hFFFF_FFFF;
        if (busop) begin
            for (int i = 0; i <= gd; i++) begin
                chk({tag, "_bus_req"}, {31'h0, bus.bus_req}, 32'h1);
                chk({tag, "_bus_we"}, {31'h0, bus.bus_we}, {31'h0, wr});
                chk({tag, "_bus_addr"}, bus.bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, "_bus_wmask"}, {28'h0, bus.bus_wmask}, {28'h0, emask});
                if (wr) chk({tag, "_bus_wdata"}, bus.bus_wdata, ewdata);
                chk({tag, "_busy"}, {31'h0, core.req_ready}, 32'h0);
                if (i < gd) @(negedge clk);
            end
            bus.bus_gnt = 1'b1;
            @(negedge clk);
            bus.bus_gnt = 1'b0;
            chk({tag, "_req_drop"}, {31'h0, bus.bus_req}, 32'h0);
            if (isld) begin
                repeat (rv) @(negedge clk);
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = rword;
                @(negedge clk);
                bus.bus_rvalid = 1'b0;
                bus.bus_rdata  = 32'h5A5A_5A5A;
            end
        end else begin
            chk({tag, "_no_bus"}, {31'h0, bus.bus_req}, 32'h0);
        end
        for (int k = 0; k < 20 && core.req_ready !== 1'b1; k++) @(negedge clk);
        chk({tag, "_done"}, {31'h0, core.req_ready}, 32'h1);
        chk({tag, "_idle_bus"}, {31'h0, bus.bus_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        core.req_valid = 1'b0;
        core.MemRd     = 1'b0;
        core.MemWr     = 1'b0;
        core.MemOp     = OP_W;
        core.addr      = 32'h0;
        core.wdata     = 32'h0;
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, core.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, core.resp_valid}, 32'h0);
        chk("rst_rdata", core.rdata, 32'h0);
        chk("rst_misalign", {31'h0, core.misalign}, 32'h0);
        chk("rst_bus_req", {31'h0, bus.bus_req}, 32'h0);
        chk("rst_bus_we", {31'h0, bus.bus_we}, 32'h0);
        chk("rst_bus_addr", bus.bus_addr, 32'h0);
        chk("rst_bus_wmask", {28'h0, bus.bus_wmask}, 32'h0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'h0);
        rst = 1'b0;

        //      tag      rd    wr    op     addr          wdata         gd rv rword         exp_rd        mis   mask     ewdata
        access("lb3",   1'b1, 1'b0, OP_B,  32'h8000_0003, 32'h0,        0, 0, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0);
        access("sh2",   1'b0, 1'b1, OP_H,  32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h0,        32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD);
        access("lw6",   1'b1, 1'b0, OP_W,  32'h8000_0006, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        access("sw_gd5",1'b0, 1'b1, OP_W,  32'h8000_0010, 32'hDEAD_BEEF, 5, 0, 32'h0,        32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF);
        access("lbu3",  1'b1, 1'b0, OP_BU, 32'h8000_0003, 32'h0,        0, 0, 32'h80FF_1234, 32'h0000_0080, 1'b0, 4'b0000, 32'h0);
        access("lh2",   1'b1, 1'b0, OP_H,  32'h8000_0002, 32'h0,        1, 0, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 4'b0000, 32'h0);
        access("lhu0",  1'b1, 1'b0, OP_HU, 32'h8000_0000, 32'h0,        0, 0, 32'h80FF_1234, 32'h0000_1234, 1'b0, 4'b0000, 32'h0);
        access("lb1",   1'b1, 1'b0, OP_B,  32'h8000_0001, 32'h0,        0, 0, 32'h80FF_1234, 32'h0000_0012, 1'b0, 4'b0000, 32'h0);
        access("lw_rv2",1'b1, 1'b0, OP_W,  32'h8000_0100, 32'h0,        0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0);
        access("sb1",   1'b0, 1'b1, OP_B,  32'h8000_0001, 32'h1234_56A5, 0, 0, 32'h0,        32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5);
        access("sh0",   1'b0, 1'b1, OP_HU, 32'h8000_0004, 32'h9999_7E01, 2, 0, 32'h0,        32'h0,        1'b0, 4'b0011, 32'h7E01_7E01);
        access("rdwr",  1'b1, 1'b1, OP_W,  32'h8000_0020, 32'h1122_3344, 0, 0, 32'h0,        32'h0,        1'b0, 4'b1111, 32'h1122_3344);
        access("lh1",   1'b1, 1'b0, OP_H,  32'h8000_0001, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        access("sh3",   1'b0, 1'b1, OP_H,  32'h8000_0003, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        access("sw2",   1'b0, 1'b1, OP_W,  32'h8000_0002, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0);
        access("noop",  1'b0, 1'b0, OP_W,  32'h8000_0040, 32'h0,        0, 0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0);

        // Stray read data while idle must not touch rdata
        @(negedge clk);
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = 32'hDEAD_0000;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        chk("stray_rvalid_rdata", core.rdata, 32'hCAFE_F00D);
        access("noop2", 1'b0, 1'b0, OP_B,  32'h0,         32'h0,        0, 0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0);
        access("lb0",   1'b1, 1'b0, OP_B,  32'h8000_0000, 32'h0,        0, 0, 32'h0000_007F, 32'h0000_007F, 1'b0, 4'b0000, 32'h0);

        // Reset while waiting for read data abandons the load
        @(negedge clk);
        core.req_valid = 1'b1;
        core.MemRd     = 1'b1;
        core.MemOp     = OP_W;
        core.addr      = 32'h8000_0200;
        @(negedge clk);
        core.req_valid = 1'b0;
        core.MemRd     = 1'b0;
        bus.bus_gnt    = 1'b1;
        @(negedge clk);
        bus.bus_gnt    = 1'b0;
        chk("wait_busy", {31'h0, core.req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'h0, core.req_ready}, 32'h1);
        chk("arst_bus_req", {31'h0, bus.bus_req}, 32'h0);
        chk("arst_bus_addr", bus.bus_addr, 32'h0);
        chk("arst_rdata", core.rdata, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        rst            = 1'b0;
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        chk("abandon_rdata", core.rdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("abandon_no_resp", {31'h0, core.resp_valid}, 32'h0);
        end
        access("post_rst", 1'b0, 1'b0, OP_W, 32'h0,       32'h0,        0, 0, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0);
        access("lhu2",  1'b1, 1'b0, OP_HU, 32'h8000_0002, 32'h0,        0, 0, 32'h80FF_1234, 32'h0000_80FF, 1'b0, 4'b0000, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
